prefetch_fetch_unit: RTL and testbench

PREFETCH_FETCH_UNIT -- requirements
Module: prefetch_fetch_unit

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 59 +++++
 rtl/prefetch_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_prefetch_fetch_unit.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fetch_pkg
// Brief    : Shared constants and queue-entry type for the prefetch fetch unit
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int INSTR_W      = 32;
    localparam int PC_INC       = 4;
    localparam int DEFAULT_XLEN = 32;
    localparam int MAX_XLEN     = 64;

    localparam logic [MAX_XLEN-1:0] DEFAULT_RESET_PC = '0;

    // Sized for the widest legal XLEN; narrower builds leave the top bits zero.
    typedef struct packed {
        logic [MAX_XLEN-1:0] pc;
        logic [INSTR_W-1:0]  instr;
    } fetch_entry_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO with flush; extra pointer bit separates full/empty
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_ptr_one = (c_ptr_w + 1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_ptr_w:0] r_wptr;
    logic [c_ptr_w:0] r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty    = (r_wptr == r_rptr);
    assign full     = (r_wptr[c_ptr_w] != r_rptr[c_ptr_w]) &&
                      (r_wptr[c_ptr_w-1:0] == r_rptr[c_ptr_w-1:0]);
    assign count    = r_wptr - r_rptr;
    assign pop_data = r_mem[r_rptr[c_ptr_w-1:0]];

    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign w_do_push = push && (!full || pop);
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + c_ptr_one;
            if (w_do_pop)  r_rptr <= r_rptr + c_ptr_one;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush) begin
            r_mem[r_wptr[c_ptr_w-1:0]] <= push_data;
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/prefetch_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : prefetch_fetch_unit
// Brief    : Instruction prefetcher with bounded in-flight requests and redirect
// Revision : 1.0 - initial release
// ============================================================================
module prefetch_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = DEFAULT_XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [XLEN-1:0]    dec_pc,
    output logic               misalign_err
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    logic [XLEN-1:0]    r_fetch_pc;
    logic [c_cnt_w-1:0] r_outst;
    logic [c_cnt_w-1:0] r_drop_cnt;
    logic               r_hold;
    logic               r_misalign;
    logic [XLEN-1:0]    r_rec_pc [DEPTH];
    logic [c_ptr_w-1:0] r_rec_wp;
    logic [c_ptr_w-1:0] r_rec_rp;

    logic               w_blank;
    logic [c_cnt_w:0]   w_committed;
    logic               w_room;
    logic               w_accept;
    logic               w_drop;
    logic               w_push;
    logic               w_pop;
    logic [c_cnt_w-1:0] w_outst_next;
    fetch_entry_t       w_push_entry;
    fetch_entry_t       w_head;
    logic               w_empty;
    logic               w_unused_full;
    logic [c_cnt_w-1:0] w_occ;

    // Outputs are blanked during reset and for the first cycle after it.
    assign w_blank = rst || r_hold;

    assign w_committed = {1'b0, r_outst} + {1'b0, w_occ};
    assign w_room      = (w_committed < (c_cnt_w + 1)'(DEPTH));

    assign imem_req_valid = !w_blank && !redirect_valid && w_room;
    assign imem_req_addr  = w_blank ? RESET_PC : r_fetch_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;

    assign w_outst_next = r_outst + c_cnt_w'(w_accept) - c_cnt_w'(imem_resp_valid);

    // Anything returning in the redirect cycle or while stale requests drain is discarded.
    assign w_drop = redirect_valid || (r_drop_cnt != '0);
    assign w_push = imem_resp_valid && !w_drop;

    assign dec_valid = !w_blank && !w_empty;
    assign w_pop     = dec_valid && dec_ready;
    assign dec_instr = dec_valid ? w_head.instr : '0;
    assign dec_pc    = dec_valid ? w_head.pc[XLEN-1:0] : '0;

    assign misalign_err = r_misalign && !w_blank;

    always_comb begin
        w_push_entry       = '0;
        w_push_entry.pc    = MAX_XLEN'(r_rec_pc[r_rec_rp]);
        w_push_entry.instr = imem_resp_data;
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .flush     (redirect_valid),
        .pop_data  (w_head),
        .full      (w_unused_full),
        .empty     (w_empty),
        .count     (w_occ)
    );

    generate
        if (XLEN < MAX_XLEN) begin : g_pc_narrow
            logic w_unused_pc_hi;
            assign w_unused_pc_hi = ^w_head.pc[MAX_XLEN-1:XLEN];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_outst    <= '0;
            r_drop_cnt <= '0;
            r_hold     <= 1'b1;
            r_misalign <= 1'b0;
            r_rec_wp   <= '0;
            r_rec_rp   <= '0;
        end else begin
            r_hold     <= 1'b0;
            r_misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            r_outst    <= w_outst_next;
            if (w_accept)        r_rec_wp <= r_rec_wp + c_ptr_one;
            if (imem_resp_valid) r_rec_rp <= r_rec_rp + c_ptr_one;
            if (redirect_valid) begin
                r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
                r_drop_cnt <= w_outst_next;
            end else begin
                if (w_accept) r_fetch_pc <= r_fetch_pc + XLEN'(PC_INC);
                if (imem_resp_valid && (r_drop_cnt != '0)) begin
                    r_drop_cnt <= r_drop_cnt - c_cnt_one;
                end
            end
        end
    end

    // PC of every accepted request, consumed in order as responses (kept or dropped) return.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_rec_pc[r_rec_wp] <= r_fetch_pc;
        end
    end

endmodule : prefetch_fetch_unit
`default_nettype wire

// File: tb/tb_prefetch_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_prefetch_fetch_unit
// Brief    : Directed and randomized checks of the prefetcher against a PC-stream model
// Revision : 1.0 - initial release
// ============================================================================
module tb_prefetch_fetch_unit;

    localparam int          XLEN   = 32;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        misalign_err;

    prefetch_fetch_unit #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_instr       (dec_instr),
        .dec_pc          (dec_pc),
        .misalign_err    (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_pc;
        int          epoch;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } dent_t;

    // Memory in flight (in request order) and the instructions decode should see next.
    mreq_t       memq[$];
    dent_t       mq[$];
    logic [31:0] acc_log[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          epoch = 0;
    logic [31:0] fpc_m = RST_PC;
    bit          hold_m = 1'b0;
    bit          mis_m = 1'b0;
    int          resp_pct = 100;
    int          lat_fixed = 1;

    logic        s_req_valid;
    logic [31:0] s_addr;
    logic        s_dec_valid;
    logic [31:0] s_dec_pc;
    logic [31:0] s_dec_instr;
    logic        s_mis;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rst             = 1'b1;
            imem_req_ready  = 1'($urandom_range(1));
            dec_ready       = 1'($urandom_range(1));
            redirect_valid  = 1'b0;
            redirect_pc     = '0;
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
            @(negedge clk);
            check("rst_req_valid", imem_req_valid, 0);
            check("rst_dec_valid", dec_valid, 0);
            check("rst_misalign", misalign_err, 0);
            check("rst_dec_instr", dec_instr, 0);
            check("rst_dec_pc", dec_pc, 0);
            check("rst_req_addr", imem_req_addr, RST_PC);
        end
        memq.delete();
        mq.delete();
        epoch++;
        fpc_m  = RST_PC;
        hold_m = 1'b1;
        mis_m  = 1'b0;
    endtask

    task automatic step(input bit rdy, input bit drdy, input bit redir, input logic [31:0] rpc);
        mreq_t r;
        bit    resp_now;
        bit    exp_rv;
        bit    acc;
        bit    pop;
        int    lat;
        @(posedge clk); #1;
        cyc++;
        rst            = 1'b0;
        imem_req_ready = rdy;
        dec_ready      = drdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        resp_now       = 1'b0;
        if (memq.size() != 0 && memq[0].due <= cyc && $urandom_range(99) < resp_pct) begin
            r               = memq.pop_front();
            resp_now        = 1'b1;
            imem_resp_valid = 1'b1;
            imem_resp_data  = instr_of(r.addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        @(negedge clk);
        s_req_valid = imem_req_valid;
        s_addr      = imem_req_addr;
        s_dec_valid = dec_valid;
        s_dec_pc    = dec_pc;
        s_dec_instr = dec_instr;
        s_mis       = misalign_err;

        // Requests in flight (including the one answered now) plus queued must stay below DEPTH.
        exp_rv = !hold_m && !redir && ((memq.size() + int'(resp_now) + mq.size()) < DEPTH);
        check("req_valid", s_req_valid, exp_rv);
        if (exp_rv) check("req_addr", s_addr, fpc_m);
        check("dec_valid", s_dec_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            check("dec_pc", s_dec_pc, mq[0].pc);
            check("dec_instr", s_dec_instr, mq[0].instr);
        end else if (hold_m) begin
            check("hold_dec_pc", s_dec_pc, 0);
            check("hold_dec_instr", s_dec_instr, 0);
            check("hold_req_addr", s_addr, RST_PC);
        end
        check("misalign_err", s_mis, mis_m);

        acc = s_req_valid && rdy;
        pop = s_dec_valid && drdy;
        if (acc) begin
            acc_log.push_back(s_addr);
            lat = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4));
            memq.push_back('{addr: s_addr, exp_pc: fpc_m, epoch: epoch, due: cyc + lat});
            fpc_m = fpc_m + 32'd4;
        end
        if (pop && mq.size() != 0) void'(mq.pop_front());
        if (resp_now && !redir && r.epoch == epoch) begin
            mq.push_back('{pc: r.exp_pc, instr: instr_of(r.addr)});
        end
        if (redir) begin
            mq.delete();
            epoch++;
            fpc_m = {rpc[31:2], 2'b00};
        end
        mis_m  = redir && (rpc[1:0] != 2'b00);
        hold_m = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          first;
        logic [31:0] first_pc;
        logic [31:0] resume;
        int          n;
        bit          redir;
        logic [31:0] rpc;

        rst             = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        dec_ready       = 1'b0;

        // Straight-line fetch from reset with single-cycle memory.
        resp_pct = 100; lat_fixed = 1;
        do_reset(3);
        acc_log.delete();
        first = -1; first_pc = 'x;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b0, '0);
            if (s_dec_valid && first < 0) begin first = i; first_pc = s_dec_pc; end
        end
        check("t1_first_dec_cycle", 64'(first), 64'(3));
        check("t1_first_dec_pc", first_pc, 32'h0);
        check("t1_acc_count_ge3", acc_log.size() >= 3, 1);
        if (acc_log.size() >= 3) begin
            check("t1_req0", acc_log[0], 32'h0);
            check("t1_req1", acc_log[1], 32'h4);
            check("t1_req2", acc_log[2], 32'h8);
        end

        // Stalled decode: the queue fills and fetch stops at exactly DEPTH requests.
        do_reset(2);
        acc_log.delete();
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b0, '0);
        check("t2_acc_count", acc_log.size(), DEPTH);
        check("t2_req_valid_stalled", s_req_valid, 0);
        resume = 'x;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b0, '0);
            if (acc_log.size() > DEPTH) begin resume = acc_log[DEPTH]; break; end
        end
        check("t2_resume_addr", resume, 32'h10);

        // Redirect with two requests in flight; latency L=3 gives first decode L+2 later.
        lat_fixed = 3;
        do_reset(2);
        acc_log.delete();
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        check("t3_outstanding", acc_log.size(), 2);
        step(1'b1, 1'b1, 1'b1, 32'h100);
        n = -1; first_pc = 'x;
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 1'b1, 1'b0, '0);
            if (s_dec_valid && n < 0) begin n = i; first_pc = s_dec_pc; end
        end
        check("t3_redirect_latency", 64'(n), 64'(5));
        check("t3_first_pc", first_pc, 32'h100);

        // Misaligned redirect target.
        lat_fixed = 1;
        do_reset(2);
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 32'h102);
        step(1'b1, 1'b1, 1'b0, '0);
        check("t4_misalign_pulse", s_mis, 1);
        check("t4_req_valid", s_req_valid, 1);
        check("t4_req_addr", s_addr, 32'h100);
        step(1'b1, 1'b1, 1'b0, '0);
        check("t4_misalign_clear", s_mis, 0);

        // Reset with a full queue, then with requests outstanding.
        do_reset(2);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, '0);
        check("t5_full_dec_valid", s_dec_valid, 1);
        do_reset(1);
        step(1'b1, 1'b1, 1'b0, '0);
        lat_fixed = 6;
        do_reset(2);
        acc_log.delete();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, '0);
        check("t5_outstanding", acc_log.size(), 3);
        do_reset(1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, '0);

        // Random traffic against the PC-stream scoreboard.
        lat_fixed = 0; resp_pct = 80;
        do_reset(2);
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(999) == 0) begin
                do_reset(1 + int'($urandom_range(2)));
            end else begin
                redir = !hold_m && ($urandom_range(49) == 0);
                rpc   = ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                 : 32'($urandom);
                step($urandom_range(9) < 7, $urandom_range(9) < 6, redir, rpc);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_prefetch_fetch_unit
`default_nettype wire
